// File: rtl/game_stats_counter.sv
// rtl/game_stats_counter.sv - per-frame event qualification plus lives/score/fruit/timer counters
module game_stats_counter #(
  parameter int FRAMES_PER_SEC      = 30,
  parameter int GAME_SECONDS        = 99,
  parameter int HIT_COOLDOWN_FRAMES = 60,
  parameter int FRUIT_POINTS        = 2,
  parameter int MAX_FRUITS          = 10
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       game_on,
  input  logic       fruit_eaten,
  input  logic       fruit_lost,
  input  logic       monster_collision,
  input  logic       missile_hit,
  input  logic       key_touch,
  output logic [1:0] livesCounter,
  output logic [3:0] scoreCounter,
  output logic [3:0] fruitsCounter,
  output logic [6:0] timeLeft,
  output logic       timer_end,
  output logic       key_collision,
  output logic       hurtPulse
);

  localparam int               DIV_W     = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]       TIME_LOAD = 7'(GAME_SECONDS);
  localparam logic [7:0]       COOL_LOAD = 8'(HIT_COOLDOWN_FRAMES);
  localparam logic [3:0]       FRUIT_MAX = 4'(MAX_FRUITS);
  localparam logic [4:0]       FRUIT_ADD = 5'(FRUIT_POINTS);

  logic [1:0]       lives_q, lives_d;
  logic [3:0]       score_q, score_d;
  logic [3:0]       fruits_q, fruits_d;
  logic [6:0]       time_q, time_d;
  logic             timer_end_q, timer_end_d;
  logic             key_pulse_q, key_pulse_d;
  logic             hurt_pulse_q, hurt_pulse_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       cool_q, cool_d;
  logic             fruit_flag_q, fruit_flag_d;
  logic             hurt_flag_q, hurt_flag_d;
  logic             key_flag_q, key_flag_d;

  logic       frame_tick;
  logic       fruit_acc;
  logic       hurt_acc;
  logic       key_acc;
  logic [4:0] score_sum;

  // Qualify each event class: at most one acceptance per frame, and only while play is active.
  always_comb begin
    frame_tick = game_on & startOfFrame;
    fruit_acc  = game_on & (fruit_eaten | fruit_lost) & (~fruit_flag_q | startOfFrame)
                 & (fruits_q < FRUIT_MAX);
    hurt_acc   = game_on & (monster_collision | missile_hit) & (~hurt_flag_q | startOfFrame)
                 & (cool_q == 8'd0) & (lives_q != 2'd3);
    key_acc    = game_on & key_touch & (~key_flag_q | startOfFrame);
  end

  // Next-state for flags, counters, cooldown, frame divider and pulses.
  always_comb begin
    fruit_flag_d = fruit_flag_q;
    hurt_flag_d  = hurt_flag_q;
    key_flag_d   = key_flag_q;
    score_d      = score_q;
    fruits_d     = fruits_q;
    lives_d      = lives_q;
    cool_d       = cool_q;
    div_d        = div_q;
    time_d       = time_q;
    timer_end_d  = timer_end_q;
    key_pulse_d  = key_acc;
    hurt_pulse_d = hurt_acc;
    score_sum    = {1'b0, score_q} + FRUIT_ADD;

    // A frame start with no acceptance re-arms the class for the new frame.
    if (fruit_acc)       fruit_flag_d = 1'b1;
    else if (frame_tick) fruit_flag_d = 1'b0;
    if (hurt_acc)        hurt_flag_d  = 1'b1;
    else if (frame_tick) hurt_flag_d  = 1'b0;
    if (key_acc)         key_flag_d   = 1'b1;
    else if (frame_tick) key_flag_d   = 1'b0;

    // Both fruit inputs high in one cycle counts once, as an eaten fruit.
    if (fruit_acc) begin
      fruits_d = fruits_q + 4'd1;
      if (fruit_eaten) score_d = score_sum[4] ? 4'hF : score_sum[3:0];
    end

    // A fresh hit reloads the invulnerability window; otherwise it drains once per frame.
    if (hurt_acc) begin
      lives_d = lives_q + 2'd1;
      cool_d  = COOL_LOAD;
    end else if (frame_tick && (cool_q != 8'd0)) begin
      cool_d = cool_q - 8'd1;
    end

    // Seconds timer: the divider wraps once per second of active frames; 0 is terminal.
    if (frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (time_q != 7'd0) begin
          time_d = time_q - 7'd1;
          if (time_q == 7'd1) timer_end_d = 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // State register with asynchronous reset to the game-start values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives_q      <= 2'd0;
      score_q      <= 4'd0;
      fruits_q     <= 4'd0;
      time_q       <= TIME_LOAD;
      timer_end_q  <= 1'b0;
      key_pulse_q  <= 1'b0;
      hurt_pulse_q <= 1'b0;
      div_q        <= '0;
      cool_q       <= 8'd0;
      fruit_flag_q <= 1'b0;
      hurt_flag_q  <= 1'b0;
      key_flag_q   <= 1'b0;
    end else begin
      lives_q      <= lives_d;
      score_q      <= score_d;
      fruits_q     <= fruits_d;
      time_q       <= time_d;
      timer_end_q  <= timer_end_d;
      key_pulse_q  <= key_pulse_d;
      hurt_pulse_q <= hurt_pulse_d;
      div_q        <= div_d;
      cool_q       <= cool_d;
      fruit_flag_q <= fruit_flag_d;
      hurt_flag_q  <= hurt_flag_d;
      key_flag_q   <= key_flag_d;
    end
  end

  assign livesCounter  = lives_q;
  assign scoreCounter  = score_q;
  assign fruitsCounter = fruits_q;
  assign timeLeft      = time_q;
  assign timer_end     = timer_end_q;
  assign key_collision = key_pulse_q;
  assign hurtPulse     = hurt_pulse_q;

endmodule

// File: tb/tb_game_stats_counter.sv
// tb/tb_game_stats_counter.sv - directed self-checking bench for game_stats_counter
module tb_game_stats_counter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof;
  logic       game_on;
  logic       fe;
  logic       fl;
  logic       mc;
  logic       mh;
  logic       kt;
  logic [1:0] lives;
  logic [3:0] score;
  logic [3:0] fruits;
  logic [6:0] tl;
  logic       te;
  logic       kc;
  logic       hp;

  int checks = 0;
  int errors = 0;
  int gf = 0;
  int fidx = 0;
  int hurt_cnt = 0;
  int key_cnt = 0;
  int width_err = 0;
  int hurt_fr_last = 0;
  int hurt_fr_prev = 0;
  int base;
  logic hp_d = 1'b0;
  logic kc_d = 1'b0;

  always #5 clk = ~clk;

  game_stats_counter #(
    .FRAMES_PER_SEC(30),
    .GAME_SECONDS(99),
    .HIT_COOLDOWN_FRAMES(60),
    .FRUIT_POINTS(2),
    .MAX_FRUITS(10)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(sof),
    .game_on(game_on),
    .fruit_eaten(fe),
    .fruit_lost(fl),
    .monster_collision(mc),
    .missile_hit(mh),
    .key_touch(kt),
    .livesCounter(lives),
    .scoreCounter(score),
    .fruitsCounter(fruits),
    .timeLeft(tl),
    .timer_end(te),
    .key_collision(kc),
    .hurtPulse(hp)
  );

  // Pulse monitor: counts pulses, remembers the frame of the last two hits, flags wide pulses.
  always @(negedge clk) begin
    hp_d <= hp;
    kc_d <= kc;
    if (hp) begin
      hurt_cnt     <= hurt_cnt + 1;
      hurt_fr_prev <= hurt_fr_last;
      hurt_fr_last <= fidx;
    end
    if (kc) key_cnt <= key_cnt + 1;
    if ((hp && hp_d) || (kc && kc_d)) width_err <= width_err + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each frame is four cycles with startOfFrame in the first.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1;
      fidx++;
      if (game_on) gf++;
      tick();
      sof = 1'b0;
      repeat (3) tick();
    end
  endtask

  initial begin
    resetN = 1'b0; sof = 1'b0; game_on = 1'b0;
    fe = 1'b0; fl = 1'b0; mc = 1'b0; mh = 1'b0; kt = 1'b0;
    repeat (3) tick();
    check("rst_lives", lives, 0);
    check("rst_score", score, 0);
    check("rst_fruits", fruits, 0);
    check("rst_time", tl, 99);
    check("rst_timer_end", te, 0);
    check("rst_key", kc, 0);
    check("rst_hurt", hp, 0);
    resetN = 1'b1;
    tick();

    // Key held with play off: nothing happens, timer frozen.
    kt = 1'b1;
    frames(2);
    check("key_game_off", key_cnt, 0);
    check("time_game_off", tl, 99);

    // Key held across two active frames: one pulse per frame.
    game_on = 1'b1;
    frames(2);
    kt = 1'b0;
    tick();
    check("key_two_frames", key_cnt, 2);

    // Fruit eaten held for three frames.
    fe = 1'b1;
    frames(3);
    fe = 1'b0;
    check("fruit3_count", fruits, 3);
    check("fruit3_score", score, 6);
    frames(1);

    // Eaten and lost together counts once, as eaten.
    fe = 1'b1; fl = 1'b1;
    frames(1);
    fe = 1'b0; fl = 1'b0;
    check("both_count", fruits, 4);
    check("both_score", score, 8);

    // Score saturates at 15.
    fe = 1'b1;
    frames(4);
    fe = 1'b0;
    check("sat_count", fruits, 8);
    check("sat_score", score, 15);

    // Lost fruits reach the ceiling; further eaten fruit is ignored.
    fl = 1'b1;
    frames(2);
    fl = 1'b0;
    check("max_count", fruits, 10);
    fe = 1'b1;
    frames(2);
    fe = 1'b0;
    check("over_max_count", fruits, 10);
    check("over_max_score", score, 15);

    // Monster held 120 frames: hits 60 frames apart.
    mc = 1'b1;
    frames(120);
    mc = 1'b0;
    tick();
    check("hurt_pulses", hurt_cnt, 2);
    check("hurt_lives", lives, 2);
    check("hurt_spacing", hurt_fr_last - hurt_fr_prev, 60);
    check("time_after_135", tl, 95);

    // Run to 1770 active frames: 59 seconds gone.
    frames(1770 - gf);
    check("time_40", tl, 40);
    check("lives_before_rst", lives, 2);

    // Asynchronous reset mid-frame.
    sof = 1'b1; fidx++; gf++;
    tick();
    sof = 1'b0;
    tick();
    resetN = 1'b0;
    #2;
    check("arst_lives", lives, 0);
    check("arst_score", score, 0);
    check("arst_fruits", fruits, 0);
    check("arst_time", tl, 99);
    check("arst_timer_end", te, 0);
    tick();
    resetN = 1'b1;
    gf = 0;
    tick();

    // Hits resume cleanly and stop at three.
    base = hurt_cnt;
    mc = 1'b1;
    frames(1);
    check("resume_lives", lives, 1);
    frames(199);
    mc = 1'b0;
    tick();
    check("third_hit_lives", lives, 3);
    check("third_hit_pulses", hurt_cnt - base, 3);
    mh = 1'b1;
    frames(65);
    mh = 1'b0;
    check("dead_lives", lives, 3);
    check("dead_pulses", hurt_cnt - base, 3);

    // Timer runs out after 2970 active frames and stays there.
    frames(2969 - gf);
    check("time_last_sec", tl, 1);
    check("timer_end_early", te, 0);
    frames(1);
    check("time_zero", tl, 0);
    check("timer_end_set", te, 1);
    frames(10);
    check("time_hold", tl, 0);
    check("timer_end_hold", te, 1);

    check("pulse_width", width_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
